tuner_ctrl_sweep_search: RTL
============================

TUNER_CTRL_SWEEP_SEARCH -- requirements
Module: tuner_ctrl_sweep_search

Interface
REQ-001 Parameter DAC_WIDTH, default 8, tuner code width.
REQ-002 Parameter ADC_WIDTH, default 8, detected power width.
REQ-003 i_clk  input  1  single clock; all logic on posedge.
REQ-004 i_rst  input  1  reset; synchronous and active-high.
REQ-005 i_search_start  input  1  one-cycle request to start a sweep.
REQ-006 i_search_abort  input  1  request to abandon the sweep in progress.
REQ-007 i_code_start  input  DAC_WIDTH  first tuner code of the sweep.
REQ-008 i_code_end  input  DAC_WIDTH  last allowed tuner code of the sweep.
REQ-009 i_code_step  input  DAC_WIDTH  code increment; a value of 0 is treated as 1.
REQ-010 o_ring_tune_val  output  1  tune code valid, towards the arbiter.
REQ-011 i_ring_tune_rdy  input  1  arbiter ready to accept the tune code.
REQ-012 o_ring_tune  output  DAC_WIDTH  tune code.
REQ-013 i_commit_val  input  1  arbiter has a synchronized commit.
REQ-014 o_commit_rdy  output  1  block ready to accept the commit.
REQ-015 i_pwr_commit  input  ADC_WIDTH  synchronized detected power.
REQ-016 i_ring_tune_commit  input  DAC_WIDTH  tune code associated with i_pwr_commit.
REQ-017 o_ctrl_active  output  1  power detection active request, towards the arbiter.
REQ-018 o_ctrl_refresh  output  1  one-cycle arbiter/detector refresh pulse.
REQ-019 o_busy  output  1  a sweep is in progress.
REQ-020 o_done  output  1  one-cycle pulse at normal sweep completion.
REQ-021 o_peak_pwr  output  ADC_WIDTH  maximum committed power of the sweep.
REQ-022 o_peak_code  output  DAC_WIDTH  committed tune code at which o_peak_pwr was observed.
REQ-023 o_num_samples  output  DAC_WIDTH+1  commits accepted in the current/last sweep.

Function
REQ-024 FSM states: IDLE, INIT, TUNE, WAIT_COMMIT, DONE.
REQ-025 Handshake fire rule: tune_fire = o_ring_tune_val && i_ring_tune_rdy; commit_fire = i_commit_val && o_commit_rdy.
REQ-026 IDLE: i_search_start -> INIT; start, end and effective step are latched in the same cycle; i_search_start is ignored in every other state.
REQ-027 INIT: o_ctrl_refresh=1 for exactly one cycle; cur_code<=start, peak_pwr<=0, peak_code<=0, num_samples<=0, peak_seen<=0; -> TUNE.
REQ-028 TUNE: o_ring_tune_val=1 and o_ring_tune=cur_code; tune_fire -> WAIT_COMMIT; o_ring_tune holds cur_code while val is stalled.
REQ-029 WAIT_COMMIT: o_commit_rdy=1; on commit_fire, num_samples increments by 1.
REQ-030 Peak update on commit_fire when peak_seen=0 or i_pwr_commit > peak_pwr (strict): peak_pwr<=i_pwr_commit, peak_code<=i_ring_tune_commit, peak_seen<=1; on ties the earliest code is kept.
REQ-031 Next-code computation in DAC_WIDTH+1 bits: nxt=cur_code+step; if nxt > end -> DONE (no wrap-around), otherwise cur_code<=nxt[DAC_WIDTH-1:0] -> TUNE.
REQ-032 start > end: exactly one point (start) is swept, then DONE.
REQ-033 DONE: o_done=1 for one cycle -> IDLE; peak and sample outputs hold until the next INIT.
REQ-034 o_ctrl_active=1 in INIT, TUNE and WAIT_COMMIT; o_busy=1 in every state except IDLE.
REQ-035 o_ring_tune_val=0 and o_commit_rdy=0 in every state other than TUNE and WAIT_COMMIT respectively.
REQ-036 Abort: i_search_abort in any non-IDLE state -> IDLE next cycle, no o_done; it takes priority over tune_fire and commit_fire, and a commit firing in that same cycle is not recorded.
REQ-037 i_search_start and i_search_abort asserted together in IDLE: abort wins; stay IDLE.
REQ-038 Minimum per-point latency: tune_fire to WAIT_COMMIT is 1 cycle; commit_fire to the next TUNE is 1 cycle.

Reset
REQ-039 On i_rst: state=IDLE; all outputs 0; cur_code, latched parameters, peak_pwr, peak_code, num_samples and peak_seen all 0.
REQ-040 i_rst mid-sweep behaves identically to power-on reset; no o_done is generated.

Verification
REQ-041 start=10, end=14, step=2, rdy always 1, commits pwr 5,9,7 -> codes 10,12,14 issued; o_done once; peak_pwr=9, peak_code=12, num_samples=3.
REQ-042 start=250, end=255, step=4, 8-bit -> codes 250,254 only (258 rejected, no wrap); num_samples=2.
REQ-043 step=0, start=3, end=5 -> codes 3,4,5; equal pwr 6,6,6 -> peak_code=3.
REQ-044 i_ring_tune_rdy low for 5 cycles in TUNE -> val held, o_ring_tune stable; commit stalled 3 cycles -> no state advance.
REQ-045 Abort asserted in WAIT_COMMIT together with commit_fire -> IDLE next cycle; num_samples unchanged; no o_done.
REQ-046 i_rst asserted in TUNE -> next cycle IDLE with all outputs 0; a new start then produces a one-cycle o_ctrl_refresh.

Source files
------------

// File: rtl/tuner_sweep_if.sv
// -----------------------------------------------------------------------------
// tuner_sweep_if
//
// Purpose:
//   Bundles the two handshake channels between the sweep controller and the
//   tuner/detector arbiter.
//   - Tune channel: the controller offers a tuner code and the arbiter accepts it.
//   - Commit channel: the arbiter returns the detected power together with the
//     code that was in force when that power was measured.
//
// Signals:
//   ring_tune_val     controller -> arbiter  tune code valid
//   ring_tune_rdy     arbiter -> controller  tune code accepted
//   ring_tune         controller -> arbiter  tune code (DAC_WIDTH)
//   commit_val        arbiter -> controller  synchronized commit available
//   commit_rdy        controller -> arbiter  controller ready for the commit
//   pwr_commit        arbiter -> controller  detected power (ADC_WIDTH)
//   ring_tune_commit  arbiter -> controller  code that belongs to pwr_commit
//
// Modports:
//   master  the sweep controller side
//   slave   the arbiter side
// -----------------------------------------------------------------------------
interface tuner_sweep_if #(
    parameter int DAC_WIDTH = 8,
    parameter int ADC_WIDTH = 8
) ();

    logic                 ring_tune_val;
    logic                 ring_tune_rdy;
    logic [DAC_WIDTH-1:0] ring_tune;
    logic                 commit_val;
    logic                 commit_rdy;
    logic [ADC_WIDTH-1:0] pwr_commit;
    logic [DAC_WIDTH-1:0] ring_tune_commit;

    modport master (
        output ring_tune_val,
        output ring_tune,
        output commit_rdy,
        input  ring_tune_rdy,
        input  commit_val,
        input  pwr_commit,
        input  ring_tune_commit
    );

    modport slave (
        input  ring_tune_val,
        input  ring_tune,
        input  commit_rdy,
        output ring_tune_rdy,
        output commit_val,
        output pwr_commit,
        output ring_tune_commit
    );

endinterface

// File: rtl/tuner_ctrl_sweep_search.sv
// -----------------------------------------------------------------------------
// tuner_ctrl_sweep_search
//
// Purpose:
//   Sweeps a tuner code from a start value to an end value in fixed steps.
//   For every code it hands the code to the arbiter, waits for the matching
//   power commit, and keeps track of the highest power seen and the code at
//   which it was seen. The earliest code wins when powers tie.
//
// Ports:
//   i_clk              clock; all logic runs on the rising edge
//   i_rst              synchronous, active-high reset
//   i_search_start     one-cycle request to start a sweep (only honoured in IDLE)
//   i_search_abort     abandon the sweep in progress (no o_done)
//   i_code_start       first code of the sweep
//   i_code_end         last code the sweep may issue
//   i_code_step        code increment (0 is treated as 1)
//   io_arb             tune/commit handshake channels (tuner_sweep_if.master)
//   o_ctrl_active      power detection request towards the arbiter
//   o_ctrl_refresh     one-cycle refresh pulse at the start of each sweep
//   o_busy             sweep in progress (any state but IDLE)
//   o_done             one-cycle pulse on normal completion
//   o_peak_pwr         highest committed power of the sweep
//   o_peak_code        code associated with o_peak_pwr
//   o_num_samples      number of commits accepted in the current/last sweep
// -----------------------------------------------------------------------------
module tuner_ctrl_sweep_search #(
    parameter int DAC_WIDTH = 8,
    parameter int ADC_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_search_start,
    input  logic                 i_search_abort,
    input  logic [DAC_WIDTH-1:0] i_code_start,
    input  logic [DAC_WIDTH-1:0] i_code_end,
    input  logic [DAC_WIDTH-1:0] i_code_step,
    tuner_sweep_if.master        io_arb,
    output logic                 o_ctrl_active,
    output logic                 o_ctrl_refresh,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [ADC_WIDTH-1:0] o_peak_pwr,
    output logic [DAC_WIDTH-1:0] o_peak_code,
    output logic [DAC_WIDTH:0]   o_num_samples
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_INIT        = 3'd1,
        S_TUNE        = 3'd2,
        S_WAIT_COMMIT = 3'd3,
        S_DONE        = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Latched sweep parameters
    logic [DAC_WIDTH-1:0] r_code_start;
    logic [DAC_WIDTH-1:0] r_code_end;
    logic [DAC_WIDTH-1:0] r_code_step;

    // Sweep datapath
    logic [DAC_WIDTH-1:0] r_cur_code;
    logic [ADC_WIDTH-1:0] r_peak_pwr;
    logic [DAC_WIDTH-1:0] r_peak_code;
    logic [DAC_WIDTH:0]   r_num_samples;
    logic                 r_peak_seen;

    // Combinational helpers
    logic                 w_tune_fire;
    logic                 w_commit_fire;
    logic                 w_commit_take;
    logic                 w_peak_update;
    logic [DAC_WIDTH:0]   w_nxt_code;
    logic                 w_past_end;
    logic [DAC_WIDTH-1:0] w_step_eff;

    logic                 w_tune_val;
    logic                 w_commit_rdy;
    logic                 w_refresh;
    logic                 w_done;
    logic                 w_active;

    // Fire terms are decoded from the state register rather than from the
    // handshake outputs themselves. The result is the same, and the
    // combinational logic below never feeds back into its own inputs.
    assign w_tune_fire   = (r_state == S_TUNE) && io_arb.ring_tune_rdy;
    assign w_commit_fire = (r_state == S_WAIT_COMMIT) && io_arb.commit_val;

    // An abort in the same cycle discards the commit entirely.
    assign w_commit_take = w_commit_fire && !i_search_abort;

    // Strict greater-than keeps the earliest code on ties. The first commit
    // of a sweep always loads, so a power of zero is still recorded.
    assign w_peak_update = !r_peak_seen || (io_arb.pwr_commit > r_peak_pwr);

    // One extra bit so that stepping past the top of the code range is seen
    // as "beyond the end" instead of wrapping back to a small code.
    assign w_nxt_code = {1'b0, r_cur_code} + {1'b0, r_code_step};
    assign w_past_end = w_nxt_code > {1'b0, r_code_end};

    assign w_step_eff = (i_code_step == '0) ? DAC_WIDTH'(1) : i_code_step;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and per-state outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_tune_val   = 1'b0;
        w_commit_rdy = 1'b0;
        w_refresh    = 1'b0;
        w_done       = 1'b0;
        w_active     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_search_start) begin
                    w_state_next = S_INIT;
                end
            end
            S_INIT: begin
                w_refresh    = 1'b1;
                w_active     = 1'b1;
                w_state_next = S_TUNE;
            end
            S_TUNE: begin
                w_tune_val = 1'b1;
                w_active   = 1'b1;
                if (w_tune_fire) begin
                    w_state_next = S_WAIT_COMMIT;
                end
            end
            S_WAIT_COMMIT: begin
                w_commit_rdy = 1'b1;
                w_active     = 1'b1;
                if (w_commit_fire) begin
                    w_state_next = w_past_end ? S_DONE : S_TUNE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Abort overrides every transition. In IDLE this also blocks a start
        // that arrives in the same cycle.
        if (i_search_abort) begin
            w_state_next = S_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Parameter latch and sweep datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_code_start  <= '0;
            r_code_end    <= '0;
            r_code_step   <= '0;
            r_cur_code    <= '0;
            r_peak_pwr    <= '0;
            r_peak_code   <= '0;
            r_num_samples <= '0;
            r_peak_seen   <= 1'b0;
        end else if (!i_search_abort) begin
            case (r_state)
                S_IDLE: begin
                    if (i_search_start) begin
                        r_code_start <= i_code_start;
                        r_code_end   <= i_code_end;
                        r_code_step  <= w_step_eff;
                    end
                end
                S_INIT: begin
                    r_cur_code    <= r_code_start;
                    r_peak_pwr    <= '0;
                    r_peak_code   <= '0;
                    r_num_samples <= '0;
                    r_peak_seen   <= 1'b0;
                end
                S_WAIT_COMMIT: begin
                    if (w_commit_take) begin
                        r_num_samples <= r_num_samples + 1'b1;
                        if (w_peak_update) begin
                            r_peak_pwr  <= io_arb.pwr_commit;
                            r_peak_code <= io_arb.ring_tune_commit;
                            r_peak_seen <= 1'b1;
                        end
                        // When the next code is past the end, cur_code keeps
                        // the last issued code and the FSM moves to DONE.
                        if (!w_past_end) begin
                            r_cur_code <= w_nxt_code[DAC_WIDTH-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign io_arb.ring_tune_val = w_tune_val;
    assign io_arb.ring_tune     = r_cur_code;
    assign io_arb.commit_rdy    = w_commit_rdy;

    assign o_ctrl_active  = w_active;
    assign o_ctrl_refresh = w_refresh;
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = w_done;
    assign o_peak_pwr     = r_peak_pwr;
    assign o_peak_code    = r_peak_code;
    assign o_num_samples  = r_num_samples;

endmodule
